m_tx_framer: RTL and testbench

Byte-framing buffer feeding the serial transmitter stage. The host command decoder writes payload bytes and marks frame ends. The block stores them in a FIFO and releases only complete frames to the serializer over a valid/ready handshake, with last-byte marking. It also exports the occupancy, frame-count and status fields that the host register map reads back.

---
 rtl/m_tx_framer.sv | 174 +++++++++++++++++
 tb/tb_m_tx_framer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_tx_framer.sv
// Byte-framing FIFO that releases only complete frames to the serializer.
// Optional CRC-8 trailer byte per frame when TX_FRAMER_CRC_EN is defined.
//
// state  | meaning
// IDLE   | no frame being sent; waits for frames_count != 0
// SEND   | presenting head byte, popping on valid & ready
// CRC    | presenting CRC trailer byte (only with TX_FRAMER_CRC_EN)
module m_tx_framer #(
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_data,
  input  logic              i_data_we,
  input  logic              i_frame_end,
  input  logic              i_flush,
  output logic [ADDR_W:0]   o_data_count,
  output logic [7:0]        o_frames_count,
  output logic [7:0]        o_status,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  output logic              o_tx_last,
  input  logic              i_tx_ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   CNT_FULL = DEPTH;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
`ifdef TX_FRAMER_CRC_EN
  localparam logic [1:0] S_CRC  = 2'd2;
`endif

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        frames_q, frames_d;
  logic              ovf_q, ovf_d;
  logic [8:0]        mem_q [DEPTH];

  logic [8:0] head;
  logic       full;
  logic       wr_en;
  logic       pop;
  logic       pop_end;
  logic       commit;

`ifdef TX_FRAMER_CRC_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction
`endif

  assign head = mem_q[rd_ptr_q];
  assign full = (count_q == CNT_FULL);

  always_comb begin
    wr_en    = i_data_we && !full && !i_flush;
    pop      = (state_q == S_SEND) && i_tx_ready && !i_flush;
    pop_end  = pop && head[8];
    commit   = wr_en && i_frame_end;

    state_d  = state_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !wr_en) count_d = count_q - CNT_ONE;

    // Saturated counter holds at 255 even when a final pop coincides with a commit.
    frames_d = frames_q;
    if (commit && !pop_end && frames_q != 8'hFF) frames_d = frames_q + 8'd1;
    else if (pop_end && !commit)                 frames_d = frames_q - 8'd1;

    ovf_d = ovf_q || (i_data_we && full);

    case (state_q)
      S_IDLE: if (frames_q != 8'd0) state_d = S_SEND;
      S_SEND: begin
        if (pop_end) begin
`ifdef TX_FRAMER_CRC_EN
          state_d = S_CRC;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef TX_FRAMER_CRC_EN
      S_CRC:  if (i_tx_ready) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef TX_FRAMER_CRC_EN
    crc_d = pop ? crc8_step(crc_q, head[7:0]) : crc_q;
    if (state_d == S_IDLE) crc_d = 8'h00;
`endif

    if (i_flush) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      frames_d = 8'd0;
      ovf_d    = 1'b0;
`ifdef TX_FRAMER_CRC_EN
      crc_d    = 8'h00;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      frames_q <= 8'd0;
      ovf_q    <= 1'b0;
`ifdef TX_FRAMER_CRC_EN
      crc_q    <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      frames_q <= frames_d;
      ovf_q    <= ovf_d;
`ifdef TX_FRAMER_CRC_EN
      crc_q    <= crc_d;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {i_frame_end, i_data};
  end

  always_comb begin
    o_tx_valid = (state_q != S_IDLE);
    o_tx_data  = 8'h00;
    o_tx_last  = 1'b0;
    if (state_q == S_SEND) begin
      o_tx_data = head[7:0];
`ifndef TX_FRAMER_CRC_EN
      o_tx_last = head[8];
`endif
    end
`ifdef TX_FRAMER_CRC_EN
    if (state_q == S_CRC) begin
      o_tx_data = crc_q;
      o_tx_last = 1'b1;
    end
`endif
  end

  assign o_data_count   = count_q;
  assign o_frames_count = frames_q;
  assign o_status       = {3'b000, (frames_q != 8'd0), (state_q != S_IDLE), ovf_q, full,
                           (count_q == '0)};

endmodule

// File: tb/tb_m_tx_framer.sv
// Scoreboard bench for m_tx_framer; expected bytes are queued at write time
// and popped by a monitor on every accepted output byte.
module tb_m_tx_framer;
  localparam int ADDR_W = 4;

  logic            clk;
  logic            rst;
  logic [7:0]      data;
  logic            we;
  logic            fend;
  logic            flush;
  logic [ADDR_W:0] data_count;
  logic [7:0]      frames_count;
  logic [7:0]      status;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_last;
  logic            tx_ready;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] exp_q[$];
  logic [7:0] tb_crc = 8'h00;

  m_tx_framer #(.ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_data_we(we), .i_frame_end(fend),
    .i_flush(flush), .o_data_count(data_count), .o_frames_count(frames_count),
    .o_status(status), .o_tx_data(tx_data), .o_tx_valid(tx_valid), .o_tx_last(tx_last),
    .i_tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial CRC-8, poly 0x07, MSB first.
  function automatic logic [7:0] crc_ref(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_byte: got data=0x%02h last=%0d, required no output", tx_data, tx_last);
      end else begin
        check("tx_byte{last,data}", int'({tx_last, tx_data}), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic fe, input logic push);
    data = d;
    we   = 1'b1;
    fend = fe;
    if (push) begin
`ifdef TX_FRAMER_CRC_EN
      exp_q.push_back({1'b0, d});
      tb_crc = crc_ref(tb_crc, d);
      if (fe) begin
        exp_q.push_back({1'b1, tb_crc});
        tb_crc = 8'h00;
      end
`else
      exp_q.push_back({fe, d});
`endif
    end
    sync();
    we   = 1'b0;
    fend = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 100);
    check(name, int'(tx_valid), 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || tx_valid || frames_count != 8'd0) && n < 300);
    check({name, "_sb_empty"}, exp_q.size(), 0);
    check({name, "_frames"}, int'(frames_count), 0);
    check({name, "_count"}, int'(data_count), 0);
  endtask

  initial begin
    rst = 1'b1; data = 8'h00; we = 1'b0; fend = 1'b0; flush = 1'b0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_data_count", int'(data_count), 0);
    check("rst_frames", int'(frames_count), 0);
    check("rst_status", int'(status), 8'h01);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_tx_valid", int'(tx_valid), 0);
    check("rst_tx_last", int'(tx_last), 0);

    // Basic frame and commit-to-valid latency.
    sync();
    tx_ready = 1'b1;
    write_byte(8'h11, 1'b0, 1'b1);
    write_byte(8'h22, 1'b0, 1'b1);
    write_byte(8'h33, 1'b1, 1'b1);
    @(negedge clk);
    check("lat_frames_after_commit", int'(frames_count), 1);
    check("lat_valid_k", int'(tx_valid), 0);
    @(negedge clk);
    check("lat_valid_k1", int'(tx_valid), 1);
    check("lat_first_data", int'(tx_data), 8'h11);
    wait_idle("basic");

    // Backpressure mid-frame.
    sync();
    tx_ready = 1'b0;
    write_byte(8'h01, 1'b0, 1'b1);
    write_byte(8'h02, 1'b0, 1'b1);
    write_byte(8'h03, 1'b0, 1'b1);
    write_byte(8'h04, 1'b1, 1'b1);
    wait_valid("bp_valid_rise");
    sync();
    tx_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", int'(tx_valid), 1);
      check("bp_hold_data", int'(tx_data), 8'h03);
    end
    sync();
    tx_ready = 1'b1;
    wait_idle("backpressure");

    // Overflow: 17 bytes into a 16-deep FIFO, then flush.
    sync();
    for (int i = 0; i < 17; i++) write_byte(8'(8'h80 + i), 1'b0, 1'b0);
    @(negedge clk);
    check("ovf_count", int'(data_count), 16);
    check("ovf_status", int'(status), 8'h06);
    sync();
    flush = 1'b1;
    sync();
    flush = 1'b0;
    @(negedge clk);
    check("ovf_flush_status", int'(status), 8'h01);
    check("ovf_flush_count", int'(data_count), 0);

    // Flush while the 2nd of 4 bytes is presented.
    sync();
    tx_ready = 1'b0;
    write_byte(8'h41, 1'b0, 1'b1);
    write_byte(8'h42, 1'b0, 1'b1);
    write_byte(8'h43, 1'b0, 1'b1);
    write_byte(8'h44, 1'b1, 1'b1);
    wait_valid("fl_valid_rise");
    sync();
    tx_ready = 1'b1;
    sync();
    tx_ready = 1'b0;
    check("fl_second_presented", int'(tx_data), 8'h42);
    flush = 1'b1;
    sync();
    flush = 1'b0;
    exp_q.delete();
    tb_crc = 8'h00;
    @(negedge clk);
    check("fl_valid", int'(tx_valid), 0);
    check("fl_count", int'(data_count), 0);
    check("fl_frames", int'(frames_count), 0);
    check("fl_status", int'(status), 8'h01);
    sync();
    tx_ready = 1'b1;
    write_byte(8'hA5, 1'b1, 1'b1);
    wait_idle("after_flush");

    // Commit of frame 2 coincides with final pop of frame 1.
    sync();
    tx_ready = 1'b1;
    write_byte(8'h51, 1'b0, 1'b1);
    write_byte(8'h52, 1'b1, 1'b1);
    write_byte(8'h61, 1'b0, 1'b1);
    write_byte(8'h62, 1'b0, 1'b1);
    write_byte(8'h63, 1'b1, 1'b1);
    @(negedge clk);
    check("b2b_frames", int'(frames_count), 1);
`ifndef TX_FRAMER_CRC_EN
    check("b2b_idle_gap", int'(tx_valid), 0);
    @(negedge clk);
    check("b2b_f2_valid", int'(tx_valid), 1);
    check("b2b_f2_data", int'(tx_data), 8'h61);
`endif
    wait_idle("back_to_back");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
